// File: rtl/coproc_instr_responder.sv
// coproc_instr_responder
//   Coprocessor-side endpoint of the HPS PIO instruction link. Synchronizes the
//   HPS enable strobe, turns its rising edge into a start event, latches and
//   validates the 29-bit instruction, issues a valid/ready command to the
//   matrix datapath, waits (with optional timeout) for the response and
//   publishes result byte and status flags back to the PIO.
//
// Parameters
//   SYNC_STAGES    enable synchronizer depth (>= 2)
//   NUM_OPS        opcodes 0..NUM_OPS-1 are legal (<= 16)
//   TIMEOUT_CYCLES max cycles in ISSUE+WAIT_RSP before abort; 0 = no timeout
//
// Ports
//   clk_clk, reset_reset_n          clock, async active-low reset
//   instruction[28:0], enable       from HPS PIO ([3:0] op, [27:4] payload, [28] parity)
//   dataout[7:0], flags[3:0]        to HPS PIO (flags: 0 busy, 1 done, 2 error, 3 overrun)
//   cmd_valid/ready/opcode/payload  command channel to the datapath
//   rsp_valid/data/error            one-cycle response strobe from the datapath
//
// Build option
//   INSTR_PARITY_EN  when defined, instruction[28] must make bits 28:0 even
//                    parity; a mismatch finishes the command with error.
//
// All outputs come straight from flops.

module coproc_instr_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OPS        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [28:0] instruction,
  input  logic        enable,
  output logic [7:0]  dataout,
  output logic [3:0]  flags,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [23:0] cmd_payload,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_error
);

`ifdef INSTR_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on the
  // edge that would make it TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  // RESOLVE is the single busy cycle for commands that never reach the
  // datapath (NOP, illegal opcode, bad parity).
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESOLVE  = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RSP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   en_prev_q, en_prev_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   res_err_q, res_err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic [7:0]             dout_q, dout_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [3:0]             cmd_op_q, cmd_op_d;
  logic [23:0]            cmd_pl_q, cmd_pl_d;

  logic en_s, sync_ok, rise, start, op_bad, par_bad, timeout_hit;

  assign en_s    = sync_q[SYNC_STAGES-1];
  // The synchronizer resets to 0, so its output only means "enable is low"
  // once real samples have propagated through. Without this qualifier an
  // enable held high across reset release would arm and fire a command.
  assign sync_ok = sync_vld_q[SYNC_STAGES-1];
  assign rise    = en_s & ~en_prev_q;
  assign start   = rise & armed_q & ~busy_q;

  assign op_bad      = ({1'b0, instruction[3:0]} >= 5'(NUM_OPS));
  assign par_bad     = PARITY_EN & (^instruction);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      sync_vld_q  <= '0;
      en_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      dout_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_pl_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_vld_q  <= sync_vld_d;
      en_prev_q   <= en_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      dout_q      <= dout_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_pl_q    <= cmd_pl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], enable};
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    en_prev_d   = en_s;
    armed_d     = armed_q | (sync_ok & ~en_s);
    cnt_d       = cnt_q;
    res_err_d   = res_err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    dout_d      = dout_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_pl_d    = cmd_pl_q;

    // A new edge while a command is in flight is only recorded, never acted on.
    if (rise && busy_q) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_op_d = instruction[3:0];
          cmd_pl_d = instruction[27:4];
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          ovr_d    = 1'b0;
          dout_d   = '0;
          cnt_d    = '0;
          if (par_bad || op_bad) begin
            state_d   = RESOLVE;
            res_err_d = 1'b1;
          end else if (instruction[3:0] == 4'd0) begin
            state_d   = RESOLVE;
            res_err_d = 1'b0;
          end else begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
          end
        end
      end

      RESOLVE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = res_err_q;
      end

      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_hit) begin
          state_d     = IDLE;
          cmd_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          dout_d      = '0;
        end else if (cmd_ready) begin
          state_d     = WAIT_RSP;
          cmd_valid_d = 1'b0;
        end
      end

      WAIT_RSP: begin
        cnt_d = cnt_q + CW'(1);
        if (rsp_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = rsp_error;
          dout_d  = rsp_data;
        end else if (timeout_hit) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dout_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dataout     = dout_q;
  assign flags       = {ovr_q, err_q, done_q, busy_q};
  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = cmd_op_q;
  assign cmd_payload = cmd_pl_q;

endmodule

// File: doc/coproc_instr_responder.md
Name: coproc_instr_responder

Overview:
- Coprocessor-side endpoint of the HPS PIO instruction link. HPS drives the 29-bit instruction and the enable strobe; this block returns the 8-bit dataout and the 4-bit flags.
- Synchronizes enable and detects its rising edge, then latches and validates the instruction.
- Issues a valid/ready command to the matrix datapath, waits for its response with a timeout, and publishes the result and status back to the PIO inputs.

Parameters:
SYNC_STAGES, 2, flops in the enable synchronizer; minimum 2.
NUM_OPS, 8, opcodes 0..NUM_OPS-1 are legal; maximum 16.
TIMEOUT_CYCLES, 1024, maximum cycles spent in ISSUE+WAIT_RSP before abort; 0 disables the timeout.

Ports:
clk_clk  in  1  single system clock.
reset_reset_n  in  1  asynchronous, active-low reset.
instruction  in  29  from HPS PIO: [3:0] opcode, [27:4] payload, [28] parity/reserved.
enable  in  1  from HPS PIO; a rising edge starts a command.
dataout  out  8  result byte to HPS PIO.
flags  out  4  status: [0] busy, [1] done, [2] error, [3] overrun.
cmd_valid  out  1  command to datapath is valid.
cmd_ready  in  1  datapath accepts the command.
cmd_opcode  out  4  latched opcode.
cmd_payload  out  24  latched instruction[27:4].
rsp_valid  in  1  datapath response strobe, one cycle.
rsp_data  in  8  response data.
rsp_error  in  1  datapath reports a failure.

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted:
  - all outputs are 0;
  - state = IDLE;
  - synchronizer flops = 0, armed = 0, timeout counter = 0.
- Enable edge detection:
  - enable passes through SYNC_STAGES flops to give en_s.
  - armed is set when en_s = 0.
  - A start event is en_s = 1 AND the previous en_s = 0 AND armed = 1.
  - Consequence: enable held high through reset release starts nothing until it first goes low.
- Latency: enable sampled high at edge k → start event at edge k+SYNC_STAGES. On that edge:
  - instruction is latched;
  - flags[0] = 1;
  - flags[1], flags[2], flags[3] and dataout are cleared.
- States:
  - IDLE:
    - start with opcode ≥ NUM_OPS → go to IDLE; done = 1, error = 1, busy = 0 (one cycle of busy), no command issued.
    - start with opcode 0 (NOP) → go to IDLE; done = 1, dataout = 0x00, no command issued.
    - any other start → go to ISSUE; cmd_valid = 1 from the next cycle.
  - ISSUE:
    - cmd_valid = 1; cmd_opcode and cmd_payload are stable.
    - cmd_valid && cmd_ready on an edge → go to WAIT_RSP; cmd_valid = 0.
  - WAIT_RSP:
    - rsp_valid → go to IDLE; dataout = rsp_data, done = 1, error = rsp_error, busy = 0.
- rsp_valid seen in the same cycle as the handshake, or while in ISSUE or IDLE, is ignored. The datapath must respond at least 1 cycle after acceptance.
- Timeout:
  - The counter clears on a start event and increments every cycle in ISSUE or WAIT_RSP.
  - On reaching TIMEOUT_CYCLES (when nonzero) → go to IDLE; cmd_valid = 0, done = 1, error = 1, dataout = 0x00.
  - A late rsp_valid after a timeout is ignored.
- Overrun: an en_s rising edge while busy sets flags[3] (sticky). The edge is otherwise ignored and the current command continues.
- Enable falling mid-command has no effect; the command completes normally.
- done, error, overrun and dataout hold until the next accepted start event.
- Flags are mutually consistent: busy = 1 implies done = 0.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- INSTR_PARITY_EN defined:
  - instruction[28] must equal the XOR of instruction[27:0] (even parity over bits 28:0).
  - On mismatch at start → go to IDLE with done = 1 and error = 1, dataout = 0x00, no command issued. The parity check takes priority over the opcode check.
- INSTR_PARITY_EN undefined: instruction[28] is ignored.

Test Plan:
- Reset with enable = 1, release, hold enable high for 20 cycles → no cmd_valid, flags = 0x0. Then drop and raise enable → command starts.
- instruction = 0x0000_0153 (opcode 3, payload 0x000015), enable rises → busy at SYNC_STAGES+1 cycles, cmd_opcode = 3, cmd_payload = 0x000015. Hold cmd_ready low 5 cycles then high → exactly one handshake. rsp_valid with rsp_data = 0xA5 → dataout = 0xA5, flags = 0x2.
- opcode 0xF (NUM_OPS = 8) → no cmd_valid, flags = 0x6. Opcode 0 → flags = 0x2, dataout = 0x00.
- TIMEOUT_CYCLES = 16, cmd_ready held high, no rsp_valid → abort exactly 16 cycles after start, flags = 0x6. A rsp_valid 3 cycles later → no change.
- Second enable edge while in WAIT_RSP, then response with rsp_error = 1 → flags = 0xE, and only one command is issued.
- With INSTR_PARITY_EN defined: instruction 0x0000_0003 (bit 28 = 0, parity even) → issued. 0x1000_0003 → flags = 0x6, no command issued.
